// File: rtl/regfile_wb_seq.sv
// Writeback sequencer: queues 32-bit writeback requests, applies size/sign
// extension at dequeue and drives the 16-bit register file port as a low-half
// write followed by a high-half write.
module regfile_wb_seq #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [4:0]  in_rd_i,
    input  logic [31:0] in_data_i,
    input  logic [1:0]  in_size_i,
    input  logic        in_ext_i,
    input  logic        flush_i,
    output logic        write_o,
    output logic [4:0]  rd_o,
    output logic        rd_h_sel_o,
    output logic [15:0] write_data_o,
    output logic        busy_o
);
    // state  | meaning
    // S_IDLE | nothing being written; waits for a queued entry
    // S_LO   | writing low half of the FIFO head
    // S_HI   | writing high half of the FIFO head; head is popped this cycle

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_BIT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  size;
        logic        ext;
    } entry_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    entry_t         fifo_q [DEPTH];
    entry_t         fifo_d [DEPTH];

    entry_t         head;
    logic           push;
    logic           pop;
    logic [15:0]    lo_half;
    logic [15:0]    hi_half;

    // Flush blocks acceptance so a flushed cycle can never enqueue.
    assign in_ready_o = (count_q < CW'(DEPTH)) && !flush_i;
    assign busy_o     = (count_q != '0);
    assign head       = fifo_q[rd_ptr_q];

    // Extension of the head entry into its two halves.
    always_comb begin
        lo_half = head.data[15:0];
        hi_half = 16'h0000;
        case (head.size)
            SZ_B: begin
                lo_half = {head.ext ? {8{head.data[7]}} : 8'h00, head.data[7:0]};
                hi_half = head.ext ? {16{head.data[7]}} : 16'h0000;
            end
            SZ_H: begin
                lo_half = head.data[15:0];
                hi_half = head.ext ? {16{head.data[15]}} : 16'h0000;
            end
            SZ_W: begin
                lo_half = head.data[15:0];
                hi_half = head.data[31:16];
            end
            SZ_BIT: begin
                lo_half = {15'b0, head.data[0]};
                hi_half = 16'h0000;
            end
            default: begin
                lo_half = 16'h0000;
                hi_half = 16'h0000;
            end
        endcase
    end

    // Next-state, FIFO pointer and occupancy update.
    always_comb begin
        push     = in_valid_i && in_ready_o && (in_rd_i != 5'd0);
        pop      = (state_q == S_HI) && !flush_i;
        state_d  = state_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fifo_d   = fifo_q;
        if (flush_i) begin
            state_d  = S_IDLE;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            case (state_q)
                S_IDLE:  if (count_q != '0) state_d = S_LO;
                S_LO:    state_d = S_HI;
                S_HI:    state_d = (count_q > CW'(1)) ? S_LO : S_IDLE;
                default: state_d = S_IDLE;
            endcase
            if (push) begin
                fifo_d[wr_ptr_q] = {in_rd_i, in_data_i, in_size_i, in_ext_i};
                wr_ptr_d         = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Register-file port outputs, decoded from state and FIFO head only.
    always_comb begin
        write_o      = 1'b0;
        rd_o         = 5'd0;
        rd_h_sel_o   = 1'b0;
        write_data_o = 16'h0000;
        case (state_q)
            S_LO: begin
                write_o      = !flush_i;
                rd_o         = head.rd;
                write_data_o = lo_half;
            end
            S_HI: begin
                write_o      = !flush_i;
                rd_o         = head.rd;
                rd_h_sel_o   = 1'b1;
                write_data_o = hi_half;
            end
            default: begin
                write_o = 1'b0;
            end
        endcase
    end

    // State, pointer, occupancy and FIFO storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fifo_q   <= fifo_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_seq.sv
// Testbench for regfile_wb_seq: behavioural request-queue model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_regfile_wb_seq;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = 5'd0;
    logic [31:0] in_data = 32'd0;
    logic [1:0]  in_size = 2'd0;
    logic        in_ext = 1'b0;
    logic        flush = 1'b0;
    logic        write;
    logic [4:0]  rd;
    logic        rd_h_sel;
    logic [15:0] write_data;
    logic        busy;

    regfile_wb_seq #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_rd_i      (in_rd),
        .in_data_i    (in_data),
        .in_size_i    (in_size),
        .in_ext_i     (in_ext),
        .flush_i      (flush),
        .write_o      (write),
        .rd_o         (rd),
        .rd_h_sel_o   (rd_h_sel),
        .write_data_o (write_data),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  size;
        logic        ext;
    } req_t;

    // Model: queue of pending requests plus which half is being written
    // (0 none, 1 low, 2 high).
    req_t mq[$];
    int   mphase = 0;

    // Write log captured at every cycle where write is asserted.
    int   log_rd[$];
    int   log_h[$];
    int   log_data[$];
    int   log_cyc[$];
    int   rd0_written = 0;

    function automatic logic [31:0] ext_val(req_t r);
        logic [31:0] v;
        case (r.size)
            2'b00:   if (r.ext) v = 32'($signed(r.data[7:0]));  else v = 32'(r.data[7:0]);
            2'b01:   if (r.ext) v = 32'($signed(r.data[15:0])); else v = 32'(r.data[15:0]);
            2'b10:   v = r.data;
            default: v = 32'(r.data[0]);
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_rd.delete(); log_h.delete(); log_data.delete(); log_cyc.delete();
    endtask

    // Reference model update on each clock edge and asynchronous reset.
    initial forever begin
        int  n;
        bit  acc;
        req_t r;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            mphase = 0;
        end else begin
            n   = mq.size();
            acc = in_valid && (n < DEPTH) && !flush;
            if (flush) begin
                mq.delete();
                mphase = 0;
            end else begin
                case (mphase)
                    0: if (n > 0) mphase = 1;
                    1: mphase = 2;
                    default: begin
                        mphase = (n > 1) ? 1 : 0;
                        void'(mq.pop_front());
                    end
                endcase
                if (acc && in_rd != 5'd0) begin
                    r.rd = in_rd; r.data = in_data; r.size = in_size; r.ext = in_ext;
                    mq.push_back(r);
                end
            end
        end
    end

    // Compare process: every output against the model, mid-cycle.
    initial forever begin
        logic        e_write;
        logic [4:0]  e_rd;
        logic        e_h;
        logic [15:0] e_data;
        logic [31:0] v;
        @(negedge clk);
        e_write = 1'b0; e_rd = 5'd0; e_h = 1'b0; e_data = 16'h0;
        if (mphase != 0 && mq.size() > 0) begin
            v       = ext_val(mq[0]);
            e_write = !flush;
            e_rd    = mq[0].rd;
            e_h     = (mphase == 2);
            e_data  = e_h ? v[31:16] : v[15:0];
        end
        chk("m_write",    32'(write),      32'(e_write));
        chk("m_rd",       32'(rd),         32'(e_rd));
        chk("m_h_sel",    32'(rd_h_sel),   32'(e_h));
        chk("m_data",     32'(write_data), 32'(e_data));
        chk("m_busy",     32'(busy),       32'(mq.size() != 0));
        chk("m_ready",    32'(in_ready),   32'((mq.size() < DEPTH) && !flush));
        if (write === 1'b1) begin
            log_rd.push_back(int'(rd));
            log_h.push_back(int'(rd_h_sel));
            log_data.push_back(int'(write_data));
            log_cyc.push_back(cyc_cnt);
            if (rd == 5'd0) rd0_written = 1;
        end
    end

    task automatic lit(input string name, input logic w, input logic [4:0] e_rd,
                       input logic h, input logic [15:0] d);
        chk({name, "_write"}, 32'(write),      32'(w));
        chk({name, "_rd"},    32'(rd),         32'(e_rd));
        chk({name, "_h"},     32'(rd_h_sel),   32'(h));
        chk({name, "_data"},  32'(write_data), 32'(d));
    endtask

    // Present a request and hold it until accepted; returns the accept cycle.
    task automatic send(input logic [4:0] r, input logic [31:0] d, input logic [1:0] sz,
                        input logic e, output int acc_cyc, output int waits);
        bit done;
        in_valid = 1'b1; in_rd = r; in_data = d; in_size = sz; in_ext = e;
        waits = 0; acc_cyc = -1; done = 0;
        while (!done && waits < 40) begin
            @(negedge clk);
            if (in_ready) begin
                acc_cyc = cyc_cnt;
                done = 1;
            end else begin
                waits++;
            end
            cyc();
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, w, total_w, acc7;
        logic [4:0]  sw_rd   [4] = '{5'd3, 5'd3, 5'd3, 5'd3};
        logic [31:0] sw_data [4] = '{32'h0000_0080, 32'h0000_0080, 32'h0000_8001, 32'hFFFF_FFFF};
        logic [1:0]  sw_size [4] = '{2'b00, 2'b00, 2'b01, 2'b11};
        logic        sw_ext  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] sw_lo   [4] = '{16'hFF80, 16'h0080, 16'h8001, 16'h0001};
        logic [15:0] sw_hi   [4] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
        logic [31:0] bd      [4] = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
        bit acc_prev;

        // Reset values
        repeat (2) @(negedge clk);
        lit("reset", 1'b0, 5'd0, 1'b0, 16'h0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(in_ready), 32'd1);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Basic W request
        send(5'd5, 32'hDEAD_BEEF, 2'b10, 1'b0, acc, w);
        cyc(); @(negedge clk); lit("w_lo", 1'b1, 5'd5, 1'b0, 16'hBEEF);
        cyc(); @(negedge clk); lit("w_hi", 1'b1, 5'd5, 1'b1, 16'hDEAD);
        cyc(); @(negedge clk); lit("w_idle", 1'b0, 5'd0, 1'b0, 16'h0);
        chk("w_idle_busy", 32'(busy), 32'd0);
        cyc();

        // Extension sweep
        for (int i = 0; i < 4; i++) begin
            send(sw_rd[i], sw_data[i], sw_size[i], sw_ext[i], acc, w);
            cyc(); @(negedge clk); lit($sformatf("ext%0d_lo", i), 1'b1, 5'd3, 1'b0, sw_lo[i]);
            cyc(); @(negedge clk); lit($sformatf("ext%0d_hi", i), 1'b1, 5'd3, 1'b1, sw_hi[i]);
            cyc();
        end

        // Burst of four W requests, valid held high
        clear_log();
        total_w = 0;
        for (int i = 0; i < 4; i++) begin
            send(5'(11 + i), bd[i], 2'b10, 1'b0, acc, w);
            total_w += w;
        end
        repeat (4) cyc();
        chk("burst_stalls", 32'(total_w), 32'd3);
        chk("burst_nwrites", 32'(log_rd.size()), 32'd8);
        for (int i = 0; i < 8 && i < log_rd.size(); i++) begin
            chk($sformatf("burst%0d_rd", i),   32'(log_rd[i]), 32'(11 + i / 2));
            chk($sformatf("burst%0d_h", i),    32'(log_h[i]),  32'(i % 2));
            chk($sformatf("burst%0d_data", i), 32'(log_data[i]),
                (i % 2) ? 32'(bd[i / 2][31:16]) : 32'(bd[i / 2][15:0]));
            chk($sformatf("burst%0d_gap", i),  32'(log_cyc[i] - log_cyc[0]), 32'(i));
        end
        cyc();

        // rd = 0 dropped, rd = 7 follows
        clear_log();
        send(5'd0, 32'h1234_5678, 2'b10, 1'b0, acc, w);
        send(5'd7, 32'hCAFE_F00D, 2'b10, 1'b0, acc7, w);
        repeat (4) cyc();
        chk("rd0_nwrites", 32'(log_rd.size()), 32'd2);
        chk("rd7_first_rd", 32'(log_rd.size() > 0 ? log_rd[0] : -1), 32'd7);
        chk("rd7_latency", 32'(log_cyc.size() > 0 ? log_cyc[0] - acc7 : -1), 32'd2);

        // Flush during HI of entry 1 with entry 2 queued
        clear_log();
        send(5'd9,  32'hAAAA_BBBB, 2'b10, 1'b0, acc, w);
        send(5'd10, 32'hCCCC_DDDD, 2'b10, 1'b0, acc, w);
        cyc();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_write", 32'(write), 32'd0);
        chk("flush_hsel", 32'(rd_h_sel), 32'd1);
        chk("flush_ready", 32'(in_ready), 32'd0);
        cyc();
        flush = 1'b0;
        @(negedge clk);
        chk("post_flush_write", 32'(write), 32'd0);
        chk("post_flush_busy", 32'(busy), 32'd0);
        repeat (4) cyc();
        chk("flush_nwrites", 32'(log_rd.size()), 32'd1);
        chk("flush_lo_rd", 32'(log_rd.size() > 0 ? log_rd[0] : -1), 32'd9);

        // Asynchronous reset during LO with a full FIFO
        send(5'd12, 32'h0102_0304, 2'b10, 1'b0, acc, w);
        send(5'd13, 32'h0506_0708, 2'b10, 1'b0, acc, w);
        clear_log();
        #2;
        rst_n = 1'b0;
        #1;
        lit("areset", 1'b0, 5'd0, 1'b0, 16'h0);
        chk("areset_busy", 32'(busy), 32'd0);
        chk("areset_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) cyc();
        chk("areset_nwrites", 32'(log_rd.size()), 32'd0);
        chk("areset_ready_after", 32'(in_ready), 32'd1);

        // Random traffic
        acc_prev = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            if (!(in_valid && !acc_prev)) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                in_data  = $urandom;
                in_size  = 2'($urandom_range(0, 3));
                in_ext   = 1'($urandom_range(0, 1));
            end
            flush = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            acc_prev = in_valid && in_ready;
            cyc();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        repeat (6) cyc();
        chk("never_rd0", 32'(rd0_written), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_seq.md
# regfile_wb_seq

Writeback sequencer for the half-width register file. Accepts full 32-bit writeback requests (ALU results, load data, bit results) through a valid/ready handshake, applies size/sign extension, and drives the register file's 16-bit write port as two consecutive half writes: low half first, then high half. A small input FIFO decouples the execute/load stage from the two-cycle write cadence.

## Interface
- `DEPTH`, default 2: FIFO entries, power of two, 2 or greater.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid_i` in 1: writeback request valid.
- `in_ready_o` out 1: request accepted when high together with `in_valid_i`.
- `in_rd_i` in 5: destination register.
- `in_data_i` in 32: raw result or load data.
- `in_size_i` in 2: `00` B, `01` H, `10` W, `11` BIT.
- `in_ext_i` in 1: 0 zero-extend, 1 sign-extend. Ignored for W and BIT.
- `flush_i` in 1: discard all queued and in-progress requests.
- `write_o` out 1: register file write enable.
- `rd_o` out 5: register file write address.
- `rd_h_sel_o` out 1: 0 low half, 1 high half.
- `write_data_o` out 16: half-word to write.
- `busy_o` out 1: FIFO non-empty or sequence in progress.

## Operation
- Accept occurs when `in_valid_i && in_ready_o`.
  - `in_ready_o = (count < DEPTH) && !flush_i`, where count is the registered FIFO occupancy.
- A request with `in_rd_i == 0` is accepted and dropped; it is never enqueued.
- Extension is computed at dequeue from the head entry. With d = data and s = `in_ext_i`:
  - B: lo = {s ? {8{d[7]}} : 8'h00, d[7:0]}; hi = s ? {16{d[7]}} : 16'h0000.
  - H: lo = d[15:0]; hi = s ? {16{d[15]}} : 16'h0000.
  - W: lo = d[15:0]; hi = d[31:16].
  - BIT: lo = {15'b0, d[0]}; hi = 16'h0000.
- FSM states: IDLE, LO, HI.
  - IDLE to LO when count > 0.
  - LO to HI, unconditional.
  - HI: the head is popped. Go to LO if count > 1, otherwise to IDLE.
- Outputs per state:
  - LO: `write_o` = 1, `rd_h_sel_o` = 0, `write_data_o` = lo.
  - HI: `write_o` = 1, `rd_h_sel_o` = 1, `write_data_o` = hi.
  - LO and HI: `rd_o` = head rd.
  - IDLE: `write_o`, `rd_o`, `rd_h_sel_o` and `write_data_o` are all 0.
- Push and pop in the same cycle are both honoured; count is unchanged.
- `flush_i` high:
  - `write_o` is forced 0 that cycle and no accept occurs.
  - Next cycle count = 0, state = IDLE, FIFO pointers reset.
  - A flush arriving in HI leaves the low half already written; this is permitted.
- `busy_o = (count != 0)`.

## Timing
- Reset values:
  - Outputs: `write_o` 0, `rd_o` 0, `rd_h_sel_o` 0, `write_data_o` 0, `busy_o` 0, `in_ready_o` 1.
  - Internal: state IDLE, count 0.
- Latency: a request accepted in cycle N (FIFO previously empty) writes LO in cycle N+2 and HI in cycle N+3.
- Throughput is one request per 2 cycles. Back-to-back requests have no IDLE gap (HI is followed directly by LO).
- The slot freed by a HI pop is visible in `in_ready_o` in the next cycle, not the same cycle.
- Full FIFO: `in_ready_o` = 0; `in_valid_i` must hold its payload until accepted.
- Pointers wrap modulo DEPTH.
- Asynchronous reset mid-sequence returns immediately to the reset values above; a partially written register is not repaired.
- Outputs are combinational from the registered state and the FIFO head only; there is no path from `in_*` to `write_*` in the same cycle.

## Test plan
- W, rd = 5, data 0xDEADBEEF, accepted in cycle 0 → cycle 2: write 1, rd 5, h 0, data 0xBEEF; cycle 3: h 1, data 0xDEAD; cycle 4: IDLE, `busy_o` 0.
- Extension sweep, rd = 3:
  - B, s = 1, data 0x00000080 → 0xFF80 then 0xFFFF.
  - B, s = 0, same data → 0x0080 then 0x0000.
  - H, s = 1, data 0x00008001 → 0x8001 then 0xFFFF.
  - BIT, data 0xFFFFFFFF → 0x0001 then 0x0000.
- Burst of 4 W requests, `in_valid_i` held high, DEPTH = 2:
  - `in_ready_o` drops once 2 entries are queued.
  - The write stream is LO,HI,LO,HI,... with no gaps across all 8 write cycles.
  - Order and data match the request order.
- rd = 0 W request followed by rd = 7 → no write ever issued to rd 0; rd 7 writes start 2 cycles after its own accept.
- `flush_i` asserted during the HI cycle of entry 1 while entry 2 is queued:
  - `write_o` is 0 in the flush cycle.
  - The next cycle is IDLE with `busy_o` 0.
  - Entry 2 is never written.
- `rst_n` pulsed low during LO with a full FIFO → all outputs at reset values immediately; after release no writes occur, and `in_ready_o` is 1.
